// File: rtl/meas_tx_sequencer.sv
// rtl/meas_tx_sequencer.sv - frame sequencer streaming meter results to the UART TX
module meas_tx_sequencer #(
  parameter int          CNT_W  = 32,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] fcount,
  input  logic [CNT_W-1:0] tcount,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             done
);

  localparam int NB    = CNT_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    MODE = 3'd2,
    FCNT = 3'd3,
    TCNT = 3'd4,
    CSUM = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic [CNT_W-1:0] fcount_q, fcount_nxt;
  logic [CNT_W-1:0] tcount_q, tcount_nxt;
  logic [7:0]       csum, csum_nxt;
  logic [7:0]       tx_data_nxt;
  logic             tx_valid_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             xfer;
  logic [7:0]       csum_sum;

  // A byte leaves on every edge where the transmitter takes it.
  assign xfer     = tx_valid & tx_ready;
  // Running sum including the byte currently on the bus; this is what the
  // checksum byte must carry when the last payload byte is accepted.
  assign csum_sum = csum + tx_data;

  // Byte k of a count, counted from the most significant byte.
  function automatic logic [7:0] cnt_byte(input logic [CNT_W-1:0] v,
                                          input logic [IDX_W-1:0] k);
    logic [CNT_W-1:0] sh;
    sh = v >> (8 * (NB - 1 - int'(k)));
    return sh[7:0];
  endfunction

  // State, byte index, snapshots and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      mode_q   <= '0;
      fcount_q <= '0;
      tcount_q <= '0;
      csum     <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      mode_q   <= mode_nxt;
      fcount_q <= fcount_nxt;
      tcount_q <= tcount_nxt;
      csum     <= csum_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Next state: advance only on a handshake, skipping count sections whose mode bit is 0.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = HDR;
          idx_nxt   = '0;
        end
      end
      HDR: begin
        if (xfer) state_nxt = MODE;
      end
      MODE: begin
        if (xfer) begin
          idx_nxt = '0;
          if (mode_q[1])      state_nxt = FCNT;
          else if (mode_q[0]) state_nxt = TCNT;
          else                state_nxt = CSUM;
        end
      end
      FCNT: begin
        if (xfer) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = mode_q[0] ? TCNT : CSUM;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      TCNT: begin
        if (xfer) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = CSUM;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      CSUM: begin
        if (xfer) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Outputs: present the byte belonging to the next state on the same edge it is entered.
  always_comb begin
    mode_nxt     = mode_q;
    fcount_nxt   = fcount_q;
    tcount_nxt   = tcount_q;
    csum_nxt     = csum;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        tx_valid_nxt = 1'b0;
        busy_nxt     = 1'b0;
        if (start) begin
          mode_nxt     = mode;
          fcount_nxt   = fcount;
          tcount_nxt   = tcount;
          csum_nxt     = '0;
          tx_data_nxt  = HEADER;
          tx_valid_nxt = 1'b1;
          busy_nxt     = 1'b1;
        end
      end
      HDR, MODE, FCNT, TCNT: begin
        if (xfer) begin
          csum_nxt = csum_sum;
          case (state_nxt)
            MODE:    tx_data_nxt = {6'b0, mode_q};
            FCNT:    tx_data_nxt = cnt_byte(fcount_q, idx_nxt);
            TCNT:    tx_data_nxt = cnt_byte(tcount_q, idx_nxt);
            CSUM:    tx_data_nxt = csum_sum;
            default: tx_data_nxt = 8'h00;
          endcase
        end
      end
      CSUM: begin
        if (xfer) begin
          tx_data_nxt  = 8'h00;
          tx_valid_nxt = 1'b0;
          busy_nxt     = 1'b0;
          done_nxt     = 1'b1;
        end
      end
      default: begin
        mode_nxt     = '0;
        fcount_nxt   = '0;
        tcount_nxt   = '0;
        csum_nxt     = '0;
        tx_data_nxt  = 8'h00;
        tx_valid_nxt = 1'b0;
        busy_nxt     = 1'b0;
      end
    endcase
  end

endmodule
